// File: rtl/shot_pos_mapper.sv
// Piecewise-linear (x, y) shot position mapper with per-axis run-time segment tables.
// Latency: 2 cycles from acceptance to out_valid when not stalled; one sample per cycle.
// Backpressure: a single advance enable (!out_valid || out_ready) freezes both stages and in_ready.
module shot_pos_mapper #(
   parameter int W       = 10,
   parameter int SEGS    = 8,
   parameter int OUT_MAX = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_we,
   input  logic                    cfg_axis,
   input  logic [$clog2(SEGS)-1:0] cfg_idx,
   input  logic                    cfg_en,
   input  logic                    cfg_mode,
   input  logic [W-1:0]            cfg_bp,
   input  logic [W:0]              cfg_val,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_x,
   input  logic [W-1:0]            in_y,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [W-1:0]            out_x,
   output logic [W-1:0]            out_y,
   output logic [$clog2(SEGS)-1:0] out_seg_x,
   output logic [$clog2(SEGS)-1:0] out_seg_y,
   output logic                    out_hit_x,
   output logic                    out_hit_y
);

   localparam int IW = $clog2(SEGS);
   localparam logic signed [W+1:0] MAX_S = (W+2)'(OUT_MAX);

   // Tables indexed [axis][entry]; axis 0 = x, axis 1 = y.
   logic [1:0][SEGS-1:0]         tbl_en;
   logic [1:0][SEGS-1:0]         tbl_mode;
   logic [1:0][SEGS-1:0][W-1:0]  tbl_bp;
   logic [1:0][SEGS-1:0][W:0]    tbl_val;

   logic                         adv;
   logic                         take;
   logic [1:0][W-1:0]            pos;
   logic [1:0][IW-1:0]           sel_seg;
   logic [1:0]                   sel_hit;

   // Stage 1 carries the selected entry's mode/value so later table writes cannot disturb it.
   logic                         s1_valid;
   logic [1:0][W-1:0]            s1_pos;
   logic [1:0][IW-1:0]           s1_seg;
   logic [1:0]                   s1_hit;
   logic [1:0]                   s1_mode;
   logic [1:0][W:0]              s1_val;

   logic [W-1:0]                 res_x;
   logic [W-1:0]                 res_y;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign take     = in_valid && adv;
   assign pos[0]   = in_x;
   assign pos[1]   = in_y;

   // Offset or constant, then clamp to [0, OUT_MAX]; an unmatched axis maps to 0.
   function automatic logic [W-1:0] apply_seg(input logic [W-1:0] p, input logic m,
                                              input logic [W:0] v, input logic h);
      logic signed [W+1:0] s;
      s = '0;
      if (m)
         s = $signed({2'b00, v[W-1:0]});
      else
         s = $signed({2'b00, p}) + $signed({v[W], v});
      if (!h)
         return '0;
      else if (s < 0)
         return '0;
      else if (s > MAX_S)
         return W'(OUT_MAX);
      else
         return s[W-1:0];
   endfunction

   // Table storage: reset to identity (entry 0 enabled, offset 0); writes are unconditional.
   always_ff @(posedge clk) begin
      if (rst) begin
         tbl_en      <= '0;
         tbl_en[0][0] <= 1'b1;
         tbl_en[1][0] <= 1'b1;
         tbl_mode    <= '0;
         tbl_bp      <= '0;
         tbl_val     <= '0;
      end else if (cfg_we) begin
         tbl_en[cfg_axis][cfg_idx]   <= cfg_en;
         tbl_mode[cfg_axis][cfg_idx] <= cfg_mode;
         tbl_bp[cfg_axis][cfg_idx]   <= cfg_bp;
         tbl_val[cfg_axis][cfg_idx]  <= cfg_val;
      end
   end

   // Segment select: highest enabled index whose breakpoint is <= position (later index wins).
   always_comb begin
      sel_seg = '0;
      sel_hit = '0;
      for (int a = 0; a < 2; a++) begin
         for (int i = 0; i < SEGS; i++) begin
            if (tbl_en[a][i] && (tbl_bp[a][i] <= pos[a])) begin
               sel_seg[a] = IW'(i);
               sel_hit[a] = 1'b1;
            end
         end
      end
   end

   // Stage 1 register: capture position and the selected entry's parameters.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_pos   <= '0;
         s1_seg   <= '0;
         s1_hit   <= '0;
         s1_mode  <= '0;
         s1_val   <= '0;
      end else if (adv) begin
         s1_valid <= take;
         s1_pos   <= pos;
         s1_seg   <= sel_seg;
         s1_hit   <= sel_hit;
         for (int a = 0; a < 2; a++) begin
            s1_mode[a] <= tbl_mode[a][sel_seg[a]];
            s1_val[a]  <= tbl_val[a][sel_seg[a]];
         end
      end
   end

   // Stage 2 arithmetic on the captured entry.
   always_comb begin
      res_x = apply_seg(s1_pos[0], s1_mode[0], s1_val[0], s1_hit[0]);
      res_y = apply_seg(s1_pos[1], s1_mode[1], s1_val[1], s1_hit[1]);
   end

   // Output register: advances only with the global enable, so stalled outputs hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_seg_x <= '0;
         out_seg_y <= '0;
         out_hit_x <= 1'b0;
         out_hit_y <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid;
         out_x     <= res_x;
         out_y     <= res_y;
         out_seg_x <= s1_seg[0];
         out_seg_y <= s1_seg[1];
         out_hit_x <= s1_hit[0];
         out_hit_y <= s1_hit[1];
      end
   end

endmodule

// File: tb/tb_shot_pos_mapper.sv
// Directed bench for shot_pos_mapper with a scoreboard queue of expected outputs.
// Expectations are hand-derived constants pushed when a sample is accepted.
// A negedge monitor pops and compares on every output transfer and checks hold/in_ready rules.
module tb_shot_pos_mapper;

   localparam int W    = 10;
   localparam int SEGS = 8;
   localparam int IW   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic          cfg_axis;
   logic [IW-1:0] cfg_idx;
   logic          cfg_en;
   logic          cfg_mode;
   logic [W-1:0]  cfg_bp;
   logic [W:0]    cfg_val;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_x;
   logic [W-1:0]  in_y;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_x;
   logic [W-1:0]  out_y;
   logic [IW-1:0] out_seg_x;
   logic [IW-1:0] out_seg_y;
   logic          out_hit_x;
   logic          out_hit_y;

   shot_pos_mapper #(.W(W), .SEGS(SEGS), .OUT_MAX(1023)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_axis(cfg_axis), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_mode(cfg_mode), .cfg_bp(cfg_bp), .cfg_val(cfg_val),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_seg_x(out_seg_x), .out_seg_y(out_seg_y), .out_hit_x(out_hit_x), .out_hit_y(out_hit_y)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  x;
      logic [W-1:0]  y;
      logic [IW-1:0] sx;
      logic [IW-1:0] sy;
      logic          hx;
      logic          hy;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   logic bp_on    = 1'b0;
   logic ro_fixed = 1'b1;
   int   bp_cnt   = 0;

   exp_t held;
   logic held_vld = 1'b0;

   int xs [8] = '{100, 200, 300, 500, 700, 800, 900, 255};
   int exs[8] = '{0, 80, 200, 450, 700, 820, 1000, 155};
   int sgs[8] = '{0, 1, 2, 3, 4, 5, 6, 2};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input int x, input int y, input int sx, input int sy,
                               input int hx, input int hy);
      exp_t e;
      e.x  = x[W-1:0];
      e.y  = y[W-1:0];
      e.sx = sx[IW-1:0];
      e.sy = sy[IW-1:0];
      e.hx = hx[0];
      e.hy = hy[0];
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the sample was accepted.
   task automatic send(input int x, input int y, input exp_t e);
      int n;
      n = 0;
      in_x     = x[W-1:0];
      in_y     = y[W-1:0];
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         compared++;
         mismatched++;
         $error("FAIL accept_timeout: observed in_ready %0d expected 1", in_ready);
      end else begin
         q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic cfg(input int axis, input int idx, input int en, input int mode,
                      input int bp, input int val);
      cfg_we   = 1'b1;
      cfg_axis = axis[0];
      cfg_idx  = idx[IW-1:0];
      cfg_en   = en[0];
      cfg_mode = mode[0];
      cfg_bp   = bp[W-1:0];
      cfg_val  = val[W:0];
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   task automatic wait_empty(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         compared++;
         mismatched++;
         $error("FAIL %s_drain: observed %0d pending expected 0", tag, q.size());
      end
   endtask

   // Downstream ready: fixed level, or a 1,0,0 repeating pattern, changed just after posedge.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (bp_on) begin
            out_ready = (bp_cnt % 3 == 0);
            bp_cnt++;
         end else begin
            out_ready = ro_fixed;
         end
      end
   end

   // Output monitor: scoreboard compare on transfer, stability while stalled, in_ready rule.
   always @(negedge clk) begin
      if (rst) begin
         held_vld = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (held_vld) begin
            check("hold_valid", out_valid, 1);
            check("hold_x", out_x, held.x);
            check("hold_y", out_y, held.y);
            check("hold_seg_x", out_seg_x, held.sx);
            check("hold_seg_y", out_seg_y, held.sy);
            check("hold_hit_x", out_hit_x, held.hx);
            check("hold_hit_y", out_hit_y, held.hy);
         end
         held_vld = out_valid && !out_ready;
         held     = '{x: out_x, y: out_y, sx: out_seg_x, sy: out_seg_y, hx: out_hit_x, hy: out_hit_y};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               compared++;
               mismatched++;
               $error("FAIL unexpected_out: observed x %0d y %0d expected no output", out_x, out_y);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("out_x", out_x, e.x);
               check("out_y", out_y, e.y);
               check("seg_x", out_seg_x, e.sx);
               check("seg_y", out_seg_y, e.sy);
               check("hit_x", out_hit_x, e.hx);
               check("hit_y", out_hit_y, e.hy);
            end
         end
      end
   end

   initial begin
      #500000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v;
      rst      = 1'b1;
      cfg_we   = 1'b0;
      cfg_axis = 1'b0;
      cfg_idx  = '0;
      cfg_en   = 1'b0;
      cfg_mode = 1'b0;
      cfg_bp   = '0;
      cfg_val  = '0;
      in_valid = 1'b0;
      in_x     = '0;
      in_y     = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_hit_x", out_hit_x, 0);
      check("rst_seg_y", out_seg_y, 0);
      rst = 1'b0;
      @(negedge clk);

      // Identity map and 2-cycle latency
      send(123, 456, mk(123, 456, 0, 0, 1, 1));
      check("lat1_valid", out_valid, 0);
      @(negedge clk);
      check("lat2_valid", out_valid, 1);
      wait_empty("identity");

      // X table load and mapping (y stays identity)
      cfg(0, 0, 1, 1, 0, 0);
      cfg(0, 1, 1, 0, 155, -120);
      cfg(0, 2, 1, 0, 255, -100);
      cfg(0, 3, 1, 0, 355, -50);
      cfg(0, 4, 1, 0, 669, 0);
      cfg(0, 5, 1, 0, 769, 20);
      cfg(0, 6, 1, 1, 869, 1000);
      for (int i = 0; i < 8; i++)
         send(xs[i], i * 50 + 7, mk(exs[i], i * 50 + 7, sgs[i], 0, 1, 1));
      wait_empty("xtable");

      // Clamp low, clamp high, no-match on y
      cfg(1, 0, 1, 0, 0, -85);
      send(500, 40, mk(450, 0, 3, 0, 1, 1));
      cfg(1, 1, 1, 0, 600, 500);
      send(500, 700, mk(450, 1023, 3, 1, 1, 1));
      cfg(1, 0, 0, 0, 0, -85);
      send(500, 10, mk(450, 0, 3, 0, 1, 0));
      wait_empty("clamp");

      // Config write in the same cycle as acceptance uses the old table
      v        = -10;
      cfg_we   = 1'b1;
      cfg_axis = 1'b0;
      cfg_idx  = 3'd2;
      cfg_en   = 1'b1;
      cfg_mode = 1'b0;
      cfg_bp   = 10'd255;
      cfg_val  = v[W:0];
      send(300, 700, mk(200, 1023, 2, 1, 1, 1));
      cfg_we = 1'b0;
      send(300, 700, mk(290, 1023, 2, 1, 1, 1));
      wait_empty("race");

      // Backpressure on identity tables
      rst = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      bp_on = 1'b1;
      for (int i = 0; i < 6; i++)
         send(60 + i * 100, 900 - i * 100, mk(60 + i * 100, 900 - i * 100, 0, 0, 1, 1));
      wait_empty("backpressure");
      bp_on = 1'b0;
      repeat (2) @(negedge clk);

      // Reset with two samples in flight
      ro_fixed = 1'b0;
      repeat (2) @(negedge clk);
      cfg(0, 0, 1, 0, 0, 7);
      send(11, 22, mk(18, 22, 0, 0, 1, 1));
      send(33, 44, mk(40, 44, 0, 0, 1, 1));
      check("inflight_valid", out_valid, 1);
      rst = 1'b1;
      q.delete();
      cfg_we   = 1'b1;
      cfg_axis = 1'b0;
      cfg_idx  = '0;
      cfg_en   = 1'b1;
      cfg_mode = 1'b1;
      cfg_bp   = '0;
      cfg_val  = 11'd999;
      @(negedge clk);
      cfg_we = 1'b0;
      check("midrst_valid", out_valid, 0);
      rst      = 1'b0;
      ro_fixed = 1'b1;
      repeat (4) @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      send(300, 5, mk(300, 5, 0, 0, 1, 1));
      wait_empty("post_reset");
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
